lbfgs_history_ctrl: RTL and testbench

- Stores the last NUM_LOOP (s, y, rho) correction triples of the L-BFGS optimiser in a circular buffer.
- Serves them to the search-direction unit in two-loop-recursion order: first loop newest to oldest, second loop oldest to newest.
- Each stream (s, y, rho) advances independently on its own read-enable strobe.
- Also supplies the valid history depth (num_loop_current) and frames each search-direction session with start/busy/done.

---
 rtl/lbfgs_history_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_lbfgs_history_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbfgs_history_ctrl.sv
// L-BFGS correction history: circular buffer of (s, y, rho) triples served in
// two-loop-recursion order (newest->oldest, then oldest->newest) per stream.
module lbfgs_history_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ELEMENTS = 50,
    parameter int NUM_LOOP     = 10,
    localparam int CW          = $clog2(NUM_LOOP + 1)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       clear,
    input  logic                                       wr_valid,
    output logic                                       wr_ready,
    input  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]    s_in,
    input  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]    y_in,
    input  logic [DATA_WIDTH-1:0]                      rho_in,
    input  logic                                       session_start,
    input  logic                                       session_abort,
    output logic                                       busy,
    output logic                                       session_done,
    output logic [CW-1:0]                              num_loop_current,
    input  logic                                       s_rd_en,
    input  logic                                       y_rd_en,
    input  logic                                       rho_rd_en,
    output logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]    s_out,
    output logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]    y_out,
    output logic [DATA_WIDTH-1:0]                      rho_out,
    output logic                                       s_valid,
    output logic                                       y_valid,
    output logic                                       rho_valid,
    output logic                                       rd_overrun
);

    localparam int PW  = (NUM_LOOP > 1) ? $clog2(NUM_LOOP) : 1;
    localparam int PW1 = PW + 1;
    localparam int JW  = $clog2(2 * NUM_LOOP + 1);

    localparam logic [CW-1:0] NL_CW     = CW'(NUM_LOOP);
    localparam logic [PW-1:0] LAST_SLOT = PW'(NUM_LOOP - 1);
    localparam logic [PW-1:0] P_ONE     = PW'(1);
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [JW-1:0] J_ONE     = JW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] vec_t;

    state_t                state_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_nxt_s;
    logic [CW-1:0]         snap_c_r;
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         wr_ptr_nxt_s;
    logic [PW-1:0]         newest_nxt_s;
    logic [PW-1:0]         snap_newest_r;
    logic [JW-1:0]         js_r;
    logic [JW-1:0]         jy_r;
    logic [JW-1:0]         jr_r;
    logic [JW-1:0]         c_j_s;
    logic [JW-1:0]         two_c_s;
    logic [PW-1:0]         s_slot_s;
    logic [PW-1:0]         y_slot_s;
    logic [PW-1:0]         r_slot_s;
    logic                  wr_fire_s;

    vec_t                  s_mem_r   [NUM_LOOP];
    vec_t                  y_mem_r   [NUM_LOOP];
    logic [DATA_WIDTH-1:0] rho_mem_r [NUM_LOOP];

    // Age of read j is j on the way back and 2C-1-j on the way forward;
    // the slot subtraction wraps explicitly since NUM_LOOP may not be 2^n.
    function automatic logic [PW-1:0] slot_of(
        input logic [JW-1:0] j,
        input logic [JW-1:0] c,
        input logic [JW-1:0] two_c,
        input logic [PW-1:0] newest
    );
        logic [JW-1:0]  age;
        logic [PW1-1:0] sum;
        if (j < c) begin
            age = j;
        end else begin
            age = two_c - J_ONE - j;
        end
        sum = PW1'(newest) + PW1'(NUM_LOOP) - PW1'(age);
        if (sum >= PW1'(NUM_LOOP)) begin
            sum = sum - PW1'(NUM_LOOP);
        end else begin
            sum = sum;
        end
        return sum[PW-1:0];
    endfunction

    assign wr_ready         = ~busy;
    assign num_loop_current = count_r;
    assign c_j_s            = JW'(snap_c_r);
    assign two_c_s          = c_j_s + c_j_s;
    assign s_slot_s         = slot_of(js_r, c_j_s, two_c_s, snap_newest_r);
    assign y_slot_s         = slot_of(jy_r, c_j_s, two_c_s, snap_newest_r);
    assign r_slot_s         = slot_of(jr_r, c_j_s, two_c_s, snap_newest_r);

    // Post-write count/pointer; clear beats a write, and both are locked out while busy.
    always_comb begin
        count_nxt_s  = count_r;
        wr_ptr_nxt_s = wr_ptr_r;
        wr_fire_s    = wr_valid & ~busy & ~clear;
        if (~busy & clear) begin
            count_nxt_s  = '0;
            wr_ptr_nxt_s = '0;
        end else if (wr_fire_s) begin
            wr_ptr_nxt_s = (wr_ptr_r == LAST_SLOT) ? '0 : wr_ptr_r + P_ONE;
            count_nxt_s  = (count_r == NL_CW) ? count_r : count_r + C_ONE;
        end else begin
            count_nxt_s  = count_r;
        end
        newest_nxt_s = (wr_ptr_nxt_s == '0) ? LAST_SLOT : wr_ptr_nxt_s - P_ONE;
    end

    // History storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            s_mem_r[wr_ptr_r]   <= s_in;
            y_mem_r[wr_ptr_r]   <= y_in;
            rho_mem_r[wr_ptr_r] <= rho_in;
        end
    end

    // Session FSM, write bookkeeping and registered read streams.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            count_r       <= '0;
            wr_ptr_r      <= '0;
            snap_c_r      <= '0;
            snap_newest_r <= '0;
            js_r          <= '0;
            jy_r          <= '0;
            jr_r          <= '0;
            busy          <= 1'b0;
            session_done  <= 1'b0;
            rd_overrun    <= 1'b0;
            s_valid       <= 1'b0;
            y_valid       <= 1'b0;
            rho_valid     <= 1'b0;
            s_out         <= '0;
            y_out         <= '0;
            rho_out       <= '0;
        end else begin
            count_r      <= count_nxt_s;
            wr_ptr_r     <= wr_ptr_nxt_s;
            s_valid      <= 1'b0;
            y_valid      <= 1'b0;
            rho_valid    <= 1'b0;
            session_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (session_start) begin
                        snap_c_r      <= count_nxt_s;
                        snap_newest_r <= newest_nxt_s;
                        js_r          <= '0;
                        jy_r          <= '0;
                        jr_r          <= '0;
                        rd_overrun    <= 1'b0;
                        busy          <= 1'b1;
                        if (count_nxt_s == '0) begin
                            state_r      <= DONE;
                            session_done <= 1'b1;
                        end else begin
                            state_r      <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (s_rd_en) begin
                        if (js_r < two_c_s) begin
                            s_out   <= s_mem_r[s_slot_s];
                            s_valid <= 1'b1;
                            js_r    <= js_r + J_ONE;
                        end else begin
                            rd_overrun <= 1'b1;
                        end
                    end
                    if (y_rd_en) begin
                        if (jy_r < two_c_s) begin
                            y_out   <= y_mem_r[y_slot_s];
                            y_valid <= 1'b1;
                            jy_r    <= jy_r + J_ONE;
                        end else begin
                            rd_overrun <= 1'b1;
                        end
                    end
                    if (rho_rd_en) begin
                        if (jr_r < two_c_s) begin
                            rho_out   <= rho_mem_r[r_slot_s];
                            rho_valid <= 1'b1;
                            jr_r      <= jr_r + J_ONE;
                        end else begin
                            rd_overrun <= 1'b1;
                        end
                    end
                    // Completion is judged on registered indices, so done follows the last valid.
                    if (session_abort) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else if ((js_r == two_c_s) && (jy_r == two_c_s) && (jr_r == two_c_s)) begin
                        state_r      <= DONE;
                        session_done <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbfgs_history_ctrl.sv
// Self-checking bench for lbfgs_history_ctrl: session vector table plus
// hand-written corner sequences; read data checked through per-stream scoreboards.
module tb_lbfgs_history_ctrl;

    localparam int DW = 32;
    localparam int NE = 4;
    localparam int NL = 4;
    localparam int CW = $clog2(NL + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clear;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [NE-1:0][DW-1:0]  s_in;
    logic [NE-1:0][DW-1:0]  y_in;
    logic [DW-1:0]          rho_in;
    logic                   session_start;
    logic                   session_abort;
    logic                   busy;
    logic                   session_done;
    logic [CW-1:0]          num_loop_current;
    logic                   s_rd_en;
    logic                   y_rd_en;
    logic                   rho_rd_en;
    logic [NE-1:0][DW-1:0]  s_out;
    logic [NE-1:0][DW-1:0]  y_out;
    logic [DW-1:0]          rho_out;
    logic                   s_valid;
    logic                   y_valid;
    logic                   rho_valid;
    logic                   rd_overrun;

    lbfgs_history_ctrl #(
        .DATA_WIDTH(DW),
        .NUM_ELEMENTS(NE),
        .NUM_LOOP(NL)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .s_in(s_in), .y_in(y_in), .rho_in(rho_in),
        .session_start(session_start), .session_abort(session_abort),
        .busy(busy), .session_done(session_done), .num_loop_current(num_loop_current),
        .s_rd_en(s_rd_en), .y_rd_en(y_rd_en), .rho_rd_en(rho_rd_en),
        .s_out(s_out), .y_out(y_out), .rho_out(rho_out),
        .s_valid(s_valid), .y_valid(y_valid), .rho_valid(rho_valid),
        .rd_overrun(rd_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    typedef struct {
        int n_wr;
        int exp_cnt;
        int seq[8];
    } vec_t;

    exp_t s_q[$];
    exp_t y_q[$];
    exp_t r_q[$];
    vec_t vt[4];
    int   seq3[6] = '{3, 2, 1, 1, 2, 3};
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NE-1:0][DW-1:0] mk_vec(input logic [15:0] tag, input int k);
        logic [NE-1:0][DW-1:0] v;
        for (int e = 0; e < NE; e++) v[e] = {tag | 16'(k), 16'(e)};
        return v;
    endfunction

    function automatic logic [DW-1:0] rho_of(input int k);
        case (k)
            1: return 32'h3F800000;
            2: return 32'h40000000;
            3: return 32'h40400000;
            4: return 32'h40800000;
            5: return 32'h40A00000;
            6: return 32'h40C00000;
            default: return 32'h41100000;
        endcase
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_k(input int k);
        wr_valid = 1'b1;
        s_in     = mk_vec(16'hA000, k);
        y_in     = mk_vec(16'hB000, k);
        rho_in   = rho_of(k);
        step();
        wr_valid = 1'b0;
    endtask

    // k>0: strobe and expect triple k; k==0: no strobe; k<0: strobe expecting nothing.
    task automatic strobe(input int ks, input int ky, input int kr);
        exp_t e;
        e.due     = cyc + 1;
        s_rd_en   = (ks != 0);
        y_rd_en   = (ky != 0);
        rho_rd_en = (kr != 0);
        if (ks > 0) begin e.data = 128'(mk_vec(16'hA000, ks)); s_q.push_back(e); end
        if (ky > 0) begin e.data = 128'(mk_vec(16'hB000, ky)); y_q.push_back(e); end
        if (kr > 0) begin e.data = 128'(rho_of(kr)); r_q.push_back(e); end
        step();
        s_rd_en   = 1'b0;
        y_rd_en   = 1'b0;
        rho_rd_en = 1'b0;
    endtask

    task automatic start();
        session_start = 1'b1;
        step();
        session_start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (session_done) got = 1'b1;
            else step();
        end
        check("session_done_seen", 128'(got), 128'(1));
        if (got) begin
            step();
            check("busy_after_done", 128'(busy), 128'(0));
            check("done_one_cycle", 128'(session_done), 128'(0));
        end
    endtask

    // Scoreboard monitors: each valid pops its expectation and checks data and latency.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (s_valid) begin
                if (s_q.size() == 0) check("s_unexpected_valid", 128'(1), 128'(0));
                else begin
                    e = s_q.pop_front();
                    check("s_data", 128'(s_out), e.data);
                    check("s_latency", 128'(cyc), 128'(e.due));
                end
            end else if (s_q.size() > 0 && s_q[0].due <= cyc) begin
                e = s_q.pop_front();
                check("s_missing_valid", 128'(0), 128'(1));
            end
            if (y_valid) begin
                if (y_q.size() == 0) check("y_unexpected_valid", 128'(1), 128'(0));
                else begin
                    e = y_q.pop_front();
                    check("y_data", 128'(y_out), e.data);
                    check("y_latency", 128'(cyc), 128'(e.due));
                end
            end else if (y_q.size() > 0 && y_q[0].due <= cyc) begin
                e = y_q.pop_front();
                check("y_missing_valid", 128'(0), 128'(1));
            end
            if (rho_valid) begin
                if (r_q.size() == 0) check("rho_unexpected_valid", 128'(1), 128'(0));
                else begin
                    e = r_q.pop_front();
                    check("rho_data", 128'(rho_out), e.data);
                    check("rho_latency", 128'(cyc), 128'(e.due));
                end
            end else if (r_q.size() > 0 && r_q[0].due <= cyc) begin
                e = r_q.pop_front();
                check("rho_missing_valid", 128'(0), 128'(1));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int js;
        int jy;
        int ks;
        int ky;
        int kr;

        vt[0].n_wr = 3; vt[0].exp_cnt = 3; vt[0].seq = '{3, 2, 1, 1, 2, 3, 0, 0};
        vt[1].n_wr = 6; vt[1].exp_cnt = 4; vt[1].seq = '{6, 5, 4, 3, 3, 4, 5, 6};
        vt[2].n_wr = 1; vt[2].exp_cnt = 1; vt[2].seq = '{1, 1, 0, 0, 0, 0, 0, 0};
        vt[3].n_wr = 5; vt[3].exp_cnt = 4; vt[3].seq = '{5, 4, 3, 2, 2, 3, 4, 5};

        rst = 1'b0; clear = 1'b0; wr_valid = 1'b0;
        s_in = '0; y_in = '0; rho_in = '0;
        session_start = 1'b0; session_abort = 1'b0;
        s_rd_en = 1'b0; y_rd_en = 1'b0; rho_rd_en = 1'b0;
        #13;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_wr_ready", 128'(wr_ready), 128'(1));
        check("rst_count", 128'(num_loop_current), 128'(0));
        check("rst_valids", 128'({s_valid, y_valid, rho_valid}), 128'(0));
        check("rst_done_overrun", 128'({session_done, rd_overrun}), 128'(0));
        check("rst_s_out", 128'(s_out), 128'(0));
        rst = 1'b1;
        step();

        // Reset in the middle of a session.
        write_k(1);
        write_k(2);
        start();
        strobe(2, 0, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_count", 128'(num_loop_current), 128'(0));
        check("mid_rst_wr_ready", 128'(wr_ready), 128'(1));
        check("mid_rst_valids", 128'({s_valid, y_valid, rho_valid, session_done, rd_overrun}), 128'(0));
        check("mid_rst_data", 128'(s_out) | 128'(y_out) | 128'(rho_out), 128'(0));
        rst = 1'b1;
        step();

        // Table of full sessions: all three streams read in lockstep.
        foreach (vt[v]) begin
            do_clear();
            for (int w = 1; w <= vt[v].n_wr; w++) write_k(w);
            check("tbl_count", 128'(num_loop_current), 128'(vt[v].exp_cnt));
            start();
            check("tbl_busy", 128'(busy), 128'(1));
            for (int i = 0; i < 2 * vt[v].exp_cnt; i++)
                strobe(vt[v].seq[i], vt[v].seq[i], vt[v].seq[i]);
            wait_done();
        end

        // Write attempted during a session is refused and leaves the sequence alone.
        do_clear();
        for (int w = 1; w <= 3; w++) write_k(w);
        start();
        wr_valid = 1'b1;
        s_in     = mk_vec(16'hA000, 9);
        y_in     = mk_vec(16'hB000, 9);
        rho_in   = rho_of(9);
        check("run_wr_ready", 128'(wr_ready), 128'(0));
        for (int i = 0; i < 6; i++) strobe(seq3[i], seq3[i], seq3[i]);
        wr_valid = 1'b0;
        wait_done();
        check("blocked_wr_count", 128'(num_loop_current), 128'(3));

        // Interleaved streams and a seventh rho strobe past the end.
        start();
        js = 0;
        jy = 0;
        for (int t = 0; t < 12; t++) begin
            ks = 0; ky = 0; kr = 0;
            if (t < 6) begin ks = seq3[js]; js++; kr = seq3[t]; end
            if (t == 6) kr = -1;
            if (t % 2 == 0) begin ky = seq3[jy]; jy++; end
            strobe(ks, ky, kr);
        end
        check("overrun_set", 128'(rd_overrun), 128'(1));
        wait_done();

        // Abort after two reads; a strobe in the abort cycle still completes.
        start();
        check("overrun_cleared", 128'(rd_overrun), 128'(0));
        strobe(3, 3, 3);
        strobe(2, 2, 2);
        session_abort = 1'b1;
        strobe(0, 0, 1);
        session_abort = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", 128'(session_done), 128'(0));
            step();
        end
        check("abort_count", 128'(num_loop_current), 128'(3));
        start();
        strobe(3, 0, 3);
        check("restart_busy", 128'(busy), 128'(1));
        session_abort = 1'b1;
        step();
        session_abort = 1'b0;
        check("restart_abort_busy", 128'(busy), 128'(0));

        // Empty history: session closes immediately.
        do_clear();
        check("empty_count", 128'(num_loop_current), 128'(0));
        start();
        check("empty_busy", 128'(busy), 128'(1));
        check("empty_done", 128'(session_done), 128'(1));
        step();
        check("empty_busy_after", 128'(busy), 128'(0));
        check("empty_done_after", 128'(session_done), 128'(0));

        step();
        step();
        check("s_queue_drained", 128'(s_q.size()), 128'(0));
        check("y_queue_drained", 128'(y_q.size()), 128'(0));
        check("rho_queue_drained", 128'(r_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
